// File: rtl/sr_cmd_gen_pkg.sv
// Shared definitions for the SR latch command generator: FSM state encoding and width.
package sr_cmd_gen_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE      = 2'd0,
      ST_DRIVE_SET = 2'd1,
      ST_DRIVE_CLR = 2'd2,
      ST_GAP       = 2'd3
   } state_e;

endpackage

// File: rtl/sr_cmd_gen_debounce.sv
// One request channel: 2-flop synchronizer, debounce counter and a one-cycle pulse
// on each rising edge of the debounced level.
module sr_cmd_gen_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_raw,
   output logic o_rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_deb;
   logic          r_deb_d;
   logic [CW-1:0] r_cnt;
   logic          r_rise;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_deb_d <= 1'b0;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         r_rise  <= r_deb & ~r_deb_d;
         if (r_sync2 != r_deb) begin
            // The level only moves after an unbroken run of disagreeing samples.
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_deb <= r_sync2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear requests to timed s/r/en commands for the SR latch.
// Define SR_CMD_GEN_CNT_EN to add saturating issued-command counters (set_cnt/clr_cnt).
//
// state     | meaning
// ST_IDLE   | no command driven, waiting for a pending request (clear wins)
// ST_DRIVE_SET | en=s=1 for HOLD_CYCLES cycles
// ST_DRIVE_CLR | en=r=1 for HOLD_CYCLES cycles
// ST_GAP    | one quiet cycle between commands, busy still high
module sr_cmd_gen
   import sr_cmd_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 2,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             set_raw,
   input  logic             clr_raw,
   output logic             s,
   output logic             r,
   output logic             en,
   output logic             busy
`ifdef SR_CMD_GEN_CNT_EN
   ,
   output logic [CNT_W-1:0] set_cnt,
   output logic [CNT_W-1:0] clr_cnt
`endif
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   logic          w_set_rise;
   logic          w_clr_rise;
   logic          w_take_set;
   logic          w_take_clr;
   state_e        r_state;
   logic [HW-1:0] r_hold;
   logic          r_pend_set;
   logic          r_pend_clr;
   logic          r_s;
   logic          r_r;
   logic          r_en;
   logic          r_busy;

   sr_cmd_gen_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_raw     (set_raw),
      .o_rise    (w_set_rise)
   );

   sr_cmd_gen_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_raw     (clr_raw),
      .o_rise    (w_clr_rise)
   );

   assign w_take_clr = (r_state == ST_IDLE) && r_pend_clr;
   assign w_take_set = (r_state == ST_IDLE) && !r_pend_clr && r_pend_set;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_hold     <= '0;
         r_pend_set <= 1'b0;
         r_pend_clr <= 1'b0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_en       <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         // A rise landing on the same edge a request is taken re-arms the flag.
         r_pend_set <= w_set_rise | (r_pend_set & ~w_take_set);
         r_pend_clr <= w_clr_rise | (r_pend_clr & ~w_take_clr);
         case (r_state)
            ST_IDLE: begin
               if (w_take_clr) begin
                  r_state <= ST_DRIVE_CLR;
                  r_hold  <= HW'(HOLD_CYCLES - 1);
                  r_en    <= 1'b1;
                  r_r     <= 1'b1;
                  r_busy  <= 1'b1;
               end else if (w_take_set) begin
                  r_state <= ST_DRIVE_SET;
                  r_hold  <= HW'(HOLD_CYCLES - 1);
                  r_en    <= 1'b1;
                  r_s     <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_DRIVE_SET, ST_DRIVE_CLR: begin
               if (r_hold == '0) begin
                  r_state <= ST_GAP;
                  r_en    <= 1'b0;
                  r_s     <= 1'b0;
                  r_r     <= 1'b0;
               end else begin
                  r_hold <= r_hold - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign s    = r_s;
   assign r    = r_r;
   assign en   = r_en;
   assign busy = r_busy;

`ifdef SR_CMD_GEN_CNT_EN
   logic [CNT_W-1:0] r_set_cnt;
   logic [CNT_W-1:0] r_clr_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_set_cnt <= '0;
         r_clr_cnt <= '0;
      end else begin
         if (w_take_set && !(&r_set_cnt)) r_set_cnt <= r_set_cnt + 1'b1;
         if (w_take_clr && !(&r_clr_cnt)) r_clr_cnt <= r_clr_cnt + 1'b1;
      end
   end

   assign set_cnt = r_set_cnt;
   assign clr_cnt = r_clr_cnt;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: directed scenarios plus random bouncy requests against a
// window-based reference model, with a simple SR latch hanging off the outputs.
module tb_sr_cmd_gen;
   import sr_cmd_gen_pkg::*;

   localparam int D  = 4;
   localparam int H  = 2;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset_n, set_raw, clr_raw;
   logic s, r, en, busy;
`ifdef SR_CMD_GEN_CNT_EN
   logic [CW-1:0] set_cnt, clr_cnt;
`endif

   always #5 clk = ~clk;

   sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .set_raw (set_raw),
      .clr_raw (clr_raw),
      .s       (s),
      .r       (r),
      .en      (en),
      .busy    (busy)
`ifdef SR_CMD_GEN_CNT_EN
      ,
      .set_cnt (set_cnt),
      .clr_cnt (clr_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;
   int t     = 0;

   // reference model state (index 0 = set, 1 = clear)
   bit     c1 [2];
   bit     c2 [2];
   bit     deb [2];
   int     since [2];
   bit     win [2][D];
   int     pend_at [2];
   bit     pend [2];
   bit     cmd_act;
   int     cmd_start;
   bit     cmd_clr;
   int     n_set, n_clr;
   bit     exp_en, exp_s, exp_r, exp_busy;
   state_e exp_st;
   bit     mq;
   bit     lq;

   // scenario observation
   bit prev_en;
   int n_starts, n_set_starts, first_en, en_hi;
   bit first_r, busy_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, t);
      end
   endtask

   task automatic model_edge(input bit rst_n, input bit raw_s, input bit raw_c);
      bit raw [2];
      bit all_diff;
      int d;
      raw[0] = raw_s;
      raw[1] = raw_c;
      if (exp_en) mq = exp_s;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            c1[i] = 0; c2[i] = 0; deb[i] = 0; since[i] = 0;
            pend[i] = 0; pend_at[i] = -100;
            for (int j = 0; j < D; j++) win[i][j] = 0;
         end
         cmd_act = 0;
         n_set   = 0;
         n_clr   = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            for (int j = D - 1; j > 0; j--) win[i][j] = win[i][j-1];
            win[i][0] = c2[i];
            c2[i] = c1[i];
            c1[i] = raw[i];
            since[i]++;
            all_diff = 1;
            for (int j = 0; j < D; j++) if (win[i][j] == deb[i]) all_diff = 0;
            if (since[i] >= D && all_diff) begin
               deb[i]   = ~deb[i];
               since[i] = 0;
               if (deb[i]) pend_at[i] = t + 2;
            end
         end
         if (!cmd_act || (t - cmd_start) >= H + 2) begin
            if (pend[1]) begin
               cmd_act = 1; cmd_start = t; cmd_clr = 1; pend[1] = 0;
               if (n_clr < 255) n_clr++;
            end else if (pend[0]) begin
               cmd_act = 1; cmd_start = t; cmd_clr = 0; pend[0] = 0;
               if (n_set < 255) n_set++;
            end
         end
         for (int i = 0; i < 2; i++) if (pend_at[i] == t) pend[i] = 1;
      end
      d = t - cmd_start;
      exp_en   = cmd_act && d < H;
      exp_s    = exp_en && !cmd_clr;
      exp_r    = exp_en && cmd_clr;
      exp_busy = cmd_act && d <= H;
      if (exp_en)        exp_st = cmd_clr ? ST_DRIVE_CLR : ST_DRIVE_SET;
      else if (exp_busy) exp_st = ST_GAP;
      else               exp_st = ST_IDLE;
   endtask

   task automatic cyc();
      logic p_en, p_s, p_r;
      p_en = en; p_s = s; p_r = r;
      @(posedge clk);
      t++;
      if (p_en === 1'b1) begin
         if (p_s === 1'b1) lq = 1;
         else if (p_r === 1'b1) lq = 0;
      end
      model_edge(reset_n, set_raw, clr_raw);
      #1;
      chk("en", 32'(en), 32'(exp_en));
      chk("s", 32'(s), 32'(exp_s));
      chk("r", 32'(r), 32'(exp_r));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("state", 32'(dut.r_state), 32'(exp_st));
      chk("s_and_r", 32'(s & r), 32'(0));
      chk("latch_q", 32'(lq), 32'(mq));
`ifdef SR_CMD_GEN_CNT_EN
      chk("set_cnt", 32'(set_cnt), 32'(n_set));
      chk("clr_cnt", 32'(clr_cnt), 32'(n_clr));
`endif
      if (en === 1'b1 && !prev_en) begin
         n_starts++;
         if (s === 1'b1) n_set_starts++;
         if (first_en < 0) begin
            first_en = t;
            first_r  = (r === 1'b1);
         end
      end
      if (en === 1'b1) en_hi++;
      if (busy === 1'b1) busy_seen = 1;
      prev_en = (en === 1'b1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic obs_clear();
      n_starts = 0; n_set_starts = 0; first_en = -1; en_hi = 0;
      first_r = 0; busy_seen = 0;
   endtask

   int e0;
   bit reached;

   initial begin
      cmd_act = 0; cmd_start = 0; cmd_clr = 0; mq = 0; lq = 0; prev_en = 0;
      exp_en = 0; exp_s = 0; exp_r = 0; exp_busy = 0; exp_st = ST_IDLE;
      for (int i = 0; i < 2; i++) pend_at[i] = -100;
      obs_clear();

      // 1: reset while set_raw is high, then a fresh rise after release
      reset_n = 0; set_raw = 1; clr_raw = 0;
      run(2);
      chk("rst_busy", 32'(busy), 32'(0));
      reset_n = 1;
      obs_clear();
      run(20);
      chk("post_rst_cmds", 32'(n_set_starts), 32'(1));
      set_raw = 0;
      run(15);

      // 2: clean set, latency and hold length
      obs_clear();
      set_raw = 1;
      e0 = t + 1;
      run(20);
      chk("latency", 32'(first_en - e0), 32'(D + 4));
      chk("hold_len", 32'(en_hi), 32'(H));
      chk("latch_set", 32'(lq), 32'(1));

      // 3: short clear glitch is ignored
      obs_clear();
      clr_raw = 1;
      run(3);
      clr_raw = 0;
      run(12);
      chk("glitch_busy", 32'(busy_seen), 32'(0));

      // 4: simultaneous set and clear: clear first, then set
      set_raw = 0; clr_raw = 0;
      run(12);
      obs_clear();
      set_raw = 1; clr_raw = 1;
      run(25);
      chk("simul_first_r", 32'(first_r), 32'(1));
      chk("simul_starts", 32'(n_starts), 32'(2));
      chk("simul_sets", 32'(n_set_starts), 32'(1));
      chk("latch_final", 32'(lq), 32'(1));

      // 5: bouncing set input yields one command
      set_raw = 0; clr_raw = 0;
      run(12);
      obs_clear();
      for (int i = 0; i < 6; i++) begin
         set_raw = i[0];
         cyc();
      end
      set_raw = 1;
      run(20);
      chk("bounce_sets", 32'(n_set_starts), 32'(1));

      // 6: reset during the first cycle of DRIVE_SET
      set_raw = 0;
      run(12);
      set_raw = 1;
      reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
         cyc();
         if (exp_st == ST_DRIVE_SET) reached = 1;
      end
      chk("reach_drive", 32'(reached), 32'(1));
      reset_n = 0;
      cyc();
      chk("mid_rst_en", 32'(en), 32'(0));
      chk("mid_rst_pend_set", 32'(dut.r_pend_set), 32'(0));
      chk("mid_rst_pend_clr", 32'(dut.r_pend_clr), 32'(0));
      reset_n = 1;
      run(20);

      // random bouncy traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         set_raw = 1'($urandom_range(0, 1));
         clr_raw = 1'($urandom_range(0, 1));
         reset_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         if (!reset_n) begin
            cyc();
            reset_n = 1;
         end
         run($urandom_range(1, 9));
      end
      set_raw = 0; clr_raw = 0;
      run(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
